// File: rtl/dmem_pkg.sv
// Shared types and bus-map constants for the data-memory responder.
package dmem_pkg;

    localparam int WORD_W = 32;
    localparam int BE_W   = 4;

    // Data-memory window as seen by the CPU.
    localparam logic [31:0] DMEM_BASE_ADDR   = 32'h1000_0000;
    localparam int          DMEM_DEPTH_WORDS = 1024;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM: synchronous read, byte-enabled write, no reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = DMEM_DEPTH_WORDS
) (
    input  logic                     clk_i,
    input  logic                     en_i,
    input  logic                     we_i,
    input  logic [BE_W-1:0]          be_i,
    input  logic [$clog2(DEPTH)-1:0] idx_i,
    input  logic [WORD_W-1:0]        wdata_i,
    output logic [WORD_W-1:0]        rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                for (int i = 0; i < BE_W; i++) begin
                    if (be_i[i]) begin
                        mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[idx_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-bus responder: req/ack handshake, programmable wait states,
// alignment/range checking in front of a byte-enabled word RAM.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = DMEM_DEPTH_WORDS,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = DMEM_BASE_ADDR
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [31:0]       addr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic [BE_W-1:0]   be_i,
    output logic              ack_o,
    output logic [WORD_W-1:0] rdata_o,
    output logic              err_o
);

    localparam int         IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q;
    logic [31:0]       addr_q;
    logic [WORD_W-1:0] wdata_q;
    logic [BE_W-1:0]   be_q;
    logic              err_q;
    logic              zero_q;

    logic              accept;
    logic              txn;
    logic              cur_we;
    logic [31:0]       cur_addr;
    logic [WORD_W-1:0] cur_wdata;
    logic [BE_W-1:0]   cur_be;
    logic [31:0]       offset;
    logic              err_now;
    logic              ram_en;
    logic [WORD_W-1:0] ram_rdata;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        txn     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    accept = 1'b1;
                    cnt_d  = WAIT_INIT;
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                        txn     = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = RESP;
                    txn     = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // With zero wait states the transaction edge is the acceptance edge,
    // so the check and RAM access must see the live inputs.
    always_comb begin
        if (state_q == IDLE) begin
            cur_we    = we_i;
            cur_addr  = addr_i;
            cur_wdata = wdata_i;
            cur_be    = be_i;
        end else begin
            cur_we    = we_q;
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
            cur_be    = be_q;
        end
    end

    assign offset  = cur_addr - BASE_ADDR;
    assign err_now = (cur_addr[1:0] != 2'b00) || ({1'b0, offset} >= SPAN);
    assign ram_en  = txn && !err_now && rst_ni;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= '0;
            be_q    <= '0;
            err_q   <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= we_i;
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
                be_q    <= be_i;
            end
            if (txn) begin
                err_q <= err_now;
                // rdata is forced to zero after an error until the next good load
                if (err_now) begin
                    zero_q <= 1'b1;
                end else if (!cur_we) begin
                    zero_q <= 1'b0;
                end
            end
        end
    end

    dmem_array #(
        .DEPTH (DEPTH_WORDS)
    ) u_array (
        .clk_i   (clk_i),
        .en_i    (ram_en),
        .we_i    (cur_we),
        .be_i    (cur_be),
        .idx_i   (offset[IDX_W+1:2]),
        .wdata_i (cur_wdata),
        .rdata_o (ram_rdata)
    );

    assign ack_o   = (state_q == RESP);
    assign err_o   = ack_o && err_q;
    assign rdata_o = zero_q ? '0 : ram_rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a WAIT_CYCLES=2 instance and a
// zero-wait instance used for back-to-back streaming.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        req = 1'b0, we = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [3:0]  be = '0;
    logic        ack, err;
    logic [31:0] rdata;

    logic        req0 = 1'b0, we0 = 1'b0;
    logic [31:0] addr0 = '0, wdata0 = '0;
    logic [3:0]  be0 = '0;
    logic        ack0, err0;
    logic [31:0] rdata0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_responder #(.WAIT_CYCLES(2)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .be_i(be), .ack_o(ack), .rdata_o(rdata), .err_o(err)
    );

    dmem_responder #(.WAIT_CYCLES(0)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req0), .we_i(we0), .addr_i(addr0),
        .wdata_i(wdata0), .be_i(be0), .ack_o(ack0), .rdata_o(rdata0), .err_o(err0)
    );

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    // lat counts negedges from request until ack is seen (-1 on timeout).
    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b, output logic [31:0] rd, output logic e,
                       output int lat, output logic ack_next);
        req = 1'b1; we = w; addr = a; wdata = d; be = b;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (ack !== 1'b1 && lat < 20);
        if (ack !== 1'b1) lat = -1;
        rd = rdata;
        e  = err;
        req = 1'b0;
        @(negedge clk);
        ack_next = ack;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b exp 0", ack); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 00000000", rdata); end
        checks++; if (u_dut.state_q !== IDLE) begin errors++; $display("FAIL reset_state got %0d exp IDLE", u_dut.state_q); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_store_load();
        logic [31:0] rd; logic e, an; int lat;
        txn(1'b1, BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, rd, e, lat, an);
        checks++; if (lat !== 3) begin errors++; $display("FAIL store_latency got %0d exp 3", lat); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL store_err got %b exp 0", e); end
        checks++; if (an !== 1'b0) begin errors++; $display("FAIL ack_single_cycle got %b exp 0", an); end
        txn(1'b0, BASE + 32'h10, 32'h0, 4'h0, rd, e, lat, an);
        checks++; if (lat !== 3) begin errors++; $display("FAIL load_latency got %0d exp 3", lat); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL load_err got %b exp 0", e); end
        checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_data got %h exp deadbeef", rd); end
    endtask

    task automatic test_byte_enable();
        logic [31:0] rd; logic e, an; int lat;
        txn(1'b1, BASE + 32'h20, 32'hAAAA_AAAA, 4'hF, rd, e, lat, an);
        txn(1'b1, BASE + 32'h20, 32'h1122_3344, 4'b0101, rd, e, lat, an);
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL be_store_err got %b exp 0", e); end
        txn(1'b0, BASE + 32'h20, 32'h0, 4'hF, rd, e, lat, an);
        checks++; if (rd !== 32'hAA22_AA44) begin errors++; $display("FAIL be_merge got %h exp aa22aa44", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic e, an; int lat;
        txn(1'b0, BASE + 32'h2, 32'h0, 4'hF, rd, e, lat, an);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL misalign_err got %b exp 1", e); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL misalign_rdata got %h exp 00000000", rd); end
        txn(1'b1, BASE + 32'd4092, 32'h1234_5678, 4'hF, rd, e, lat, an);
        txn(1'b1, BASE, 32'h600D_F00D, 4'hF, rd, e, lat, an);
        txn(1'b1, BASE + 32'd4096, 32'hCAFE_BABE, 4'hF, rd, e, lat, an);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL range_store_err got %b exp 1", e); end
        txn(1'b0, BASE + 32'd4092, 32'h0, 4'hF, rd, e, lat, an);
        checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL last_word_kept got %h exp 12345678", rd); end
        txn(1'b0, BASE, 32'h0, 4'hF, rd, e, lat, an);
        checks++; if (rd !== 32'h600D_F00D) begin errors++; $display("FAIL word0_kept got %h exp 600df00d", rd); end
        txn(1'b0, BASE - 32'd4, 32'h0, 4'hF, rd, e, lat, an);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL below_base_err got %b exp 1", e); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL below_base_rdata got %h exp 00000000", rd); end
    endtask

    task automatic test_be_zero();
        logic [31:0] rd; logic e, an; int lat;
        txn(1'b1, BASE + 32'h10, 32'hFFFF_FFFF, 4'h0, rd, e, lat, an);
        checks++; if (lat !== 3) begin errors++; $display("FAIL be0_ack_latency got %0d exp 3", lat); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL be0_err got %b exp 0", e); end
        txn(1'b0, BASE + 32'h10, 32'h0, 4'hF, rd, e, lat, an);
        checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL be0_unchanged got %h exp deadbeef", rd); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic e, an; int lat;
        int pulses = 0;
        req = 1'b1; we = 1'b1; addr = BASE + 32'h10; wdata = 32'h5555_5555; be = 4'hF;
        @(negedge clk);
        rst_n = 1'b0;
        req = 1'b0;
        #1;
        checks++; if (u_dut.state_q !== IDLE) begin errors++; $display("FAIL midrst_state got %0d exp IDLE", u_dut.state_q); end
        repeat (2) begin @(negedge clk); if (ack === 1'b1) pulses++; end
        rst_n = 1'b1;
        repeat (4) begin @(negedge clk); if (ack === 1'b1) pulses++; end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL midrst_no_ack got %0d exp 0", pulses); end
        txn(1'b0, BASE + 32'h10, 32'h0, 4'hF, rd, e, lat, an);
        checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL midrst_old_word got %h exp deadbeef", rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [4];
        vals[0] = 32'h0102_0304; vals[1] = 32'hA5A5_5A5A;
        vals[2] = 32'h0000_FFFF; vals[3] = 32'h8000_0001;
        for (int ph = 0; ph < 2; ph++) begin
            int n = 0, cyc = 0, last = 0;
            req0 = 1'b1; we0 = (ph == 0); be0 = 4'hF;
            addr0 = BASE + 32'h100; wdata0 = vals[0];
            while (n < 4 && cyc < 40) begin
                @(negedge clk);
                cyc++;
                if (ack0 === 1'b1) begin
                    if (n == 0) begin
                        checks++; if (cyc !== 1) begin errors++; $display("FAIL b2b_first_latency ph%0d got %0d exp 1", ph, cyc); end
                    end else begin
                        checks++; if (cyc - last !== 2) begin errors++; $display("FAIL b2b_spacing ph%0d n%0d got %0d exp 2", ph, n, cyc - last); end
                    end
                    checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL b2b_err ph%0d n%0d got %b exp 0", ph, n, err0); end
                    if (ph == 1) begin
                        checks++; if (rdata0 !== vals[n]) begin errors++; $display("FAIL b2b_rdata n%0d got %h exp %h", n, rdata0, vals[n]); end
                    end
                    last = cyc;
                    n++;
                    if (n < 4) begin
                        addr0  = BASE + 32'h100 + 32'(4 * n);
                        wdata0 = vals[n];
                    end
                end
            end
            req0 = 1'b0;
            checks++; if (n !== 4) begin errors++; $display("FAIL b2b_ack_count ph%0d got %0d exp 4", ph, n); end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_byte_enable();
        test_errors();
        test_be_zero();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
